frac_clock_gen: RTL

FRAC_CLOCK_GEN -- requirements
Module: frac_clock_gen

---
 rtl/frac_clock_gen_pkg.sv | 19 +
 rtl/frac_clock_gen_if.sv | 25 ++
 rtl/frac_clock_gen_nco_channel.sv | 110 +++++++++++
 rtl/frac_clock_gen.sv | 50 +++++
 4 files changed

// File: rtl/frac_clock_gen_pkg.sv
// Shared types and defaults for the fractional clock generator.
// Holds the per-channel state encoding and the default parameter values.
package frac_clock_gen_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } chan_state_e;

    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_LOCK_CYCLES = 16;

    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frac_clock_gen_if.sv
// Configuration write channel: valid/ready handshake carrying
// a target channel index and a new frequency word.
interface frac_clock_gen_if #(
    parameter int ACC_WIDTH = 24,
    parameter int CHAN_W    = 1
);
    logic                 CFG_VALID;
    logic                 CFG_READY;
    logic [CHAN_W-1:0]    CFG_CHAN;
    logic [ACC_WIDTH-1:0] CFG_INC;

    modport master (
        output CFG_VALID,
        output CFG_CHAN,
        output CFG_INC,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID,
        input  CFG_CHAN,
        input  CFG_INC,
        output CFG_READY
    );
endinterface

// File: rtl/frac_clock_gen_nco_channel.sv
// One NCO channel: phase accumulator, shadow word with pending flag,
// OFF/ACQUIRE/LOCKED state machine and lock counter.
module nco_channel
    import frac_clock_gen_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_wr,
    input  logic [ACC_WIDTH-1:0] i_wr_inc,
    output logic                 o_pending,
    output logic                 o_clk,
    output logic                 o_tick,
    output logic                 o_lock
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_CYCLES);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_inc;
    logic [ACC_WIDTH-1:0] r_shadow;
    logic                 r_pending;
    logic                 r_tick;
    logic                 r_lock;
    logic [7:0]           r_lock_cnt;
    chan_state_e          r_state;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_carry;
    logic [7:0]           w_cnt_next;

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry    = w_sum[ACC_WIDTH];
    assign w_cnt_next = r_lock_cnt + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc      <= '0;
            r_inc      <= '0;
            r_shadow   <= '0;
            r_pending  <= 1'b0;
            r_tick     <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_cnt <= '0;
            r_state    <= ST_OFF;
        end else begin
            r_tick <= 1'b0;
            // LOCK trails the state by one cycle so it rises after the tick
            r_lock <= (r_state == ST_LOCKED);
            if (!i_enable) begin
                r_state    <= ST_OFF;
                r_acc      <= '0;
                r_lock_cnt <= '0;
                r_lock     <= 1'b0;
                if (r_state == ST_OFF && r_pending) begin
                    r_inc     <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else begin
                unique case (r_state)
                    ST_OFF: begin
                        if (r_pending) begin
                            r_inc     <= r_shadow;
                            r_pending <= 1'b0;
                        end else if (r_inc != '0) begin
                            r_state <= ST_ACQUIRE;
                        end
                    end
                    ST_ACQUIRE, ST_LOCKED: begin
                        r_acc  <= w_sum[ACC_WIDTH-1:0];
                        r_tick <= w_carry;
                        // new words only land on a wrap so the output never glitches
                        if (w_carry && r_pending) begin
                            r_inc      <= r_shadow;
                            r_pending  <= 1'b0;
                            r_lock_cnt <= '0;
                            r_lock     <= 1'b0;
                            if (r_shadow == '0) begin
                                r_state <= ST_OFF;
                                r_acc   <= '0;
                                r_tick  <= 1'b0;
                            end else begin
                                r_state <= ST_ACQUIRE;
                            end
                        end else if (w_carry && r_state == ST_ACQUIRE) begin
                            r_lock_cnt <= w_cnt_next;
                            if (w_cnt_next == LOCK_N) begin
                                r_state <= ST_LOCKED;
                            end
                        end
                    end
                    default: r_state <= ST_OFF;
                endcase
            end
            if (i_wr) begin
                r_shadow  <= i_wr_inc;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_clk     = r_acc[ACC_WIDTH-1];
    assign o_tick    = r_tick;
    assign o_lock    = r_lock;

endmodule

// File: rtl/frac_clock_gen.sv
// Multi-channel fractional clock generator: decodes configuration
// writes onto per-channel NCOs and collects their outputs.
module frac_clock_gen
    import frac_clock_gen_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                REFERENCECLK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] ENABLE,
    frac_clock_gen_if.slave     cfg,
    output logic [CHANNELS-1:0] PLLOUTCORE,
    output logic [CHANNELS-1:0] TICK,
    output logic [CHANNELS-1:0] LOCK
);

    localparam int CHAN_W = chan_bits(CHANNELS);

    logic [CHANNELS-1:0] w_sel;
    logic [CHANNELS-1:0] w_pending;
    logic [CHANNELS-1:0] w_wr;
    logic                w_ready;

    // out-of-range indices select nothing, so such writes are silently dropped
    assign w_ready       = ~|(w_sel & w_pending);
    assign cfg.CFG_READY = w_ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_sel[g] = (cfg.CFG_CHAN == CHAN_W'(g));
        assign w_wr[g]  = cfg.CFG_VALID & w_ready & w_sel[g];

        nco_channel #(
            .ACC_WIDTH   (ACC_WIDTH),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_chan (
            .i_clk     (REFERENCECLK),
            .i_rst     (RESET),
            .i_enable  (ENABLE[g]),
            .i_wr      (w_wr[g]),
            .i_wr_inc  (cfg.CFG_INC),
            .o_pending (w_pending[g]),
            .o_clk     (PLLOUTCORE[g]),
            .o_tick    (TICK[g]),
            .o_lock    (LOCK[g])
        );
    end

endmodule
